id_stage: RTL and testbench
===========================

ID_STAGE -- requirements
Module: id_stage

Interface
REQ-001 The block SHALL have ports clk (in, 1, rising-edge clock) and rst_n (in, 1, asynchronous active-low reset); one clock; reset is asynchronous and active-low.
REQ-002 The block SHALL have ports if_valid (in, 1, fetch word valid), if_instr (in, 32, fetch word) and if_ready (out, 1, stage can accept).
REQ-003 The block SHALL have ports ex_ready (in, 1, EX consumes) and ex_valid (out, 1, decoded bundle valid).
REQ-004 The block SHALL have ports flush (in, 1, discard all held words), flags_in (in, 4, NZCV from EX) and flags_we (in, 1, flag write strobe).
REQ-005 The block SHALL have these outputs: first_ld (2), special_enc (1), second_ld (4), alu_oc (3), b_cond (4), dest_reg (3), pointer_reg (3), op_1_reg (3), op_2_reg (3), immediate (16), offset (16), flags (4).

Function
REQ-006 The block SHALL decode if_instr as follows:
- first_ld = [31:30]
- special_enc = [29]
- second_ld = [28:25]
- b_cond = [28:25]
- alu_oc = [24:22]
- dest_reg = [21:19]
- op_1_reg = [18:16]
- pointer_reg = [18:16]
- op_2_reg = [2:0]
- immediate = [15:0]
REQ-007 offset SHALL be {{4{instr[11]}}, instr[11:0]} (sign-extended 12-bit) when first_ld==2'b10, else 16'h0000.
REQ-008 A 32'h0000_0000 word SHALL be the NOP and SHALL decode to all-zero fields.
REQ-009 Decoded fields SHALL be captured into a two-entry skid buffer (head, tail); outputs present the head entry fields registered, with no combinational path from if_instr to outputs.
REQ-010 The buffer FSM SHALL have states EMPTY, ONE and FULL.
REQ-011 An input transfer SHALL occur when if_valid && if_ready.
REQ-012 An output transfer SHALL occur when ex_valid && ex_ready.
REQ-013 Buffer transitions SHALL be:
- EMPTY: input -> ONE.
- ONE: input only -> FULL; output only -> EMPTY; input and output together -> ONE, with the head replaced by the new word.
- FULL: output -> ONE, tail promoted to head; input is impossible in FULL.
REQ-014 if_ready SHALL be a registered signal equal to (state != FULL) and SHALL not depend combinationally on ex_ready.
REQ-015 ex_valid SHALL equal (state != EMPTY).
REQ-016 While ex_valid && !ex_ready, all decoded outputs SHALL be held stable.
REQ-017 Latency SHALL be 1 cycle from input transfer to ex_valid when EMPTY; sustained throughput SHALL be one word per cycle with ex_ready high.
REQ-018 When flush is high, the next state SHALL be EMPTY, all held decoded fields SHALL be cleared to zero and if_ready SHALL be 1 next cycle; flush SHALL take priority over a simultaneous input or output transfer, and the coincident input word SHALL be discarded.
REQ-019 The flags register SHALL load flags_in on any edge where flags_we is high, independent of buffer state and of flush; flags SHALL output the register value.
REQ-020 A simultaneous flags_we and head decode SHALL present the new flags on the cycle after the write (no bypass).

Reset
REQ-021 On rst_n low, asynchronously, the state SHALL go to EMPTY and ex_valid SHALL be 0.
REQ-022 On rst_n low, if_ready SHALL be 1 and all decoded outputs SHALL be 0.
REQ-023 On rst_n low, flags SHALL be 4'h0.
REQ-024 Reset asserted mid-transfer SHALL drop both buffered words with no partial output; the first input transfer after reset release SHALL behave as from EMPTY.

Verification
REQ-025 Reset then a single word 32'h4A5B_0007 with ex_ready=1 -> ex_valid=1 next cycle, with:
- first_ld=2'b01, special_enc=0, second_ld=4'h5, alu_oc=3'b001
- dest_reg=3, op_1_reg=3, op_2_reg=7, immediate=16'h0007, offset=0
REQ-026 Branch word 32'h8000_0FFE -> first_ld=2'b10, offset=16'hFFFE.
REQ-027 Branch word 32'h8000_07FF -> offset=16'h07FF.
REQ-028 Stream words A, B, C; ex_ready low 3 cycles after A is presented -> B is held, FULL is reached, if_ready=0 while full; releasing ex_ready delivers A, B, C in order with none lost or duplicated.
REQ-029 Back-to-back stream with ex_ready=1 -> one word out per cycle, if_ready constantly 1.
REQ-030 FULL state plus flush and if_valid in the same cycle -> next cycle ex_valid=0, if_ready=1, outputs zero, and the input word never appears.
REQ-031 flags_we=1 with flags_in=4'b1010 during flush and a stall -> flags=4'b1010 next cycle; asynchronous rst_n pulse mid-stream -> ex_valid=0 and flags=0 immediately, before the next clock edge.

Source files
------------

// File: rtl/id_stage.sv
// -----------------------------------------------------------------------------
// id_stage
//
// Instruction decode stage. Splits each 32-bit fetch word into its register,
// opcode and immediate fields and holds the result in a two-entry skid buffer
// so that the fetch side sees a registered ready signal that never depends
// combinationally on the execute side's ready.
//
// Ports
//   clk          in   1   rising-edge clock
//   rst_n        in   1   asynchronous active-low reset
//   if_valid     in   1   fetch word valid
//   if_instr     in  32   fetch word
//   if_ready     out  1   stage can accept a word (registered)
//   ex_ready     in   1   execute stage consumes the head entry
//   ex_valid     out  1   decoded bundle valid
//   flush        in   1   discard every held word
//   flags_in     in   4   NZCV from execute
//   flags_we     in   1   flag write strobe
//   first_ld     out  2   instr[31:30]
//   special_enc  out  1   instr[29]
//   second_ld    out  4   instr[28:25]
//   alu_oc       out  3   instr[24:22]
//   b_cond       out  4   instr[28:25]
//   dest_reg     out  3   instr[21:19]
//   pointer_reg  out  3   instr[18:16]
//   op_1_reg     out  3   instr[18:16]
//   op_2_reg     out  3   instr[2:0]
//   immediate    out 16   instr[15:0]
//   offset       out 16   sign-extended instr[11:0] for branches, else zero
//   flags        out  4   flag register
// -----------------------------------------------------------------------------
module id_stage (
    input  logic        clk,
    input  logic        rst_n,

    input  logic        if_valid,
    input  logic [31:0] if_instr,
    output logic        if_ready,

    input  logic        ex_ready,
    output logic        ex_valid,

    input  logic        flush,
    input  logic [3:0]  flags_in,
    input  logic        flags_we,

    output logic [1:0]  first_ld,
    output logic        special_enc,
    output logic [3:0]  second_ld,
    output logic [2:0]  alu_oc,
    output logic [3:0]  b_cond,
    output logic [2:0]  dest_reg,
    output logic [2:0]  pointer_reg,
    output logic [2:0]  op_1_reg,
    output logic [2:0]  op_2_reg,
    output logic [15:0] immediate,
    output logic [15:0] offset,
    output logic [3:0]  flags
);

    // One buffer entry: every decoded field of a single fetch word.
    typedef struct packed {
        logic [1:0]  first_ld;
        logic        special_enc;
        logic [3:0]  second_ld;
        logic [2:0]  alu_oc;
        logic [3:0]  b_cond;
        logic [2:0]  dest_reg;
        logic [2:0]  pointer_reg;
        logic [2:0]  op_1_reg;
        logic [2:0]  op_2_reg;
        logic [15:0] immediate;
        logic [15:0] offset;
    } fields_t;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } buf_state_t;

    localparam logic [1:0] LD_BRANCH = 2'b10;

    buf_state_t state_q, state_d;
    fields_t    head_q,  head_d;
    fields_t    tail_q,  tail_d;
    fields_t    dec;
    logic       if_ready_q;
    logic [3:0] flags_q;
    logic       in_xfer;
    logic       out_xfer;

    // -------------------------------------------------------------------------
    // Field decode. Pure wiring apart from the branch offset; the all-zero NOP
    // falls out naturally as an all-zero entry.
    // -------------------------------------------------------------------------
    always_comb begin
        dec             = '0;
        dec.first_ld    = if_instr[31:30];
        dec.special_enc = if_instr[29];
        dec.second_ld   = if_instr[28:25];
        dec.b_cond      = if_instr[28:25];
        dec.alu_oc      = if_instr[24:22];
        dec.dest_reg    = if_instr[21:19];
        dec.op_1_reg    = if_instr[18:16];
        dec.pointer_reg = if_instr[18:16];
        dec.op_2_reg    = if_instr[2:0];
        dec.immediate   = if_instr[15:0];
        dec.offset      = (if_instr[31:30] == LD_BRANCH)
                        ? {{4{if_instr[11]}}, if_instr[11:0]}
                        : 16'h0000;
    end

    // -------------------------------------------------------------------------
    // Handshakes. if_ready comes from a flop, so the input transfer never sees
    // ex_ready combinationally; the tail entry absorbs the word that was
    // already in flight when execute stalled.
    // -------------------------------------------------------------------------
    assign in_xfer  = if_valid && if_ready_q;
    assign out_xfer = (state_q != EMPTY) && ex_ready;

    // -------------------------------------------------------------------------
    // Buffer next-state logic.
    // -------------------------------------------------------------------------
    always_comb begin
        // NOTE: every signal driven here gets a default first so no path
        // leaves it unassigned, which would otherwise infer a latch.
        state_d = state_q;
        head_d  = head_q;
        tail_d  = tail_q;

        if (flush) begin
            // Flush wins over any coincident transfer; the incoming word is
            // dropped and both entries are cleared.
            state_d = EMPTY;
            head_d  = '0;
            tail_d  = '0;
        end else begin
            unique case (state_q)
                EMPTY: begin
                    if (in_xfer) begin
                        state_d = ONE;
                        head_d  = dec;
                    end
                end

                ONE: begin
                    if (in_xfer && out_xfer) begin
                        head_d = dec;
                    end else if (in_xfer) begin
                        state_d = FULL;
                        tail_d  = dec;
                    end else if (out_xfer) begin
                        state_d = EMPTY;
                    end
                end

                FULL: begin
                    // if_ready is low here, so only the output side can move.
                    if (out_xfer) begin
                        state_d = ONE;
                        head_d  = tail_q;
                    end
                end

                default: begin
                    state_d = EMPTY;
                end
            endcase
        end
    end

    // -------------------------------------------------------------------------
    // State and buffer registers.
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: the two entries are plain flops, not a RAM, so they are
            // reset along with the state; outputs read zero out of reset.
            state_q    <= EMPTY;
            head_q     <= '0;
            tail_q     <= '0;
            if_ready_q <= 1'b1;
        end else begin
            // NOTE: non-blocking assignments so every register samples the
            // pre-edge values computed above, independent of statement order.
            state_q    <= state_d;
            head_q     <= head_d;
            tail_q     <= tail_d;
            if_ready_q <= (state_d != FULL);
        end
    end

    // Flag register: written whenever strobed, regardless of flush or stall.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            flags_q <= 4'h0;
        end else if (flags_we) begin
            flags_q <= flags_in;
        end
    end

    // -------------------------------------------------------------------------
    // Outputs: straight from registers.
    // -------------------------------------------------------------------------
    assign if_ready    = if_ready_q;
    assign ex_valid    = (state_q != EMPTY);
    assign flags       = flags_q;

    assign first_ld    = head_q.first_ld;
    assign special_enc = head_q.special_enc;
    assign second_ld   = head_q.second_ld;
    assign alu_oc      = head_q.alu_oc;
    assign b_cond      = head_q.b_cond;
    assign dest_reg    = head_q.dest_reg;
    assign pointer_reg = head_q.pointer_reg;
    assign op_1_reg    = head_q.op_1_reg;
    assign op_2_reg    = head_q.op_2_reg;
    assign immediate   = head_q.immediate;
    assign offset      = head_q.offset;

endmodule

// File: tb/tb_id_stage.sv
// -----------------------------------------------------------------------------
// tb_id_stage
//
// Directed bench for id_stage: reset state, field decode, branch offsets,
// streaming, stall/skid behaviour, flush, flag register and asynchronous reset.
// Inputs change 1 ns after the rising edge; outputs are checked there too.
// -----------------------------------------------------------------------------
module tb_id_stage;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        if_valid;
    logic [31:0] if_instr;
    logic        if_ready;
    logic        ex_ready;
    logic        ex_valid;
    logic        flush;
    logic [3:0]  flags_in;
    logic        flags_we;
    logic [1:0]  first_ld;
    logic        special_enc;
    logic [3:0]  second_ld;
    logic [2:0]  alu_oc;
    logic [3:0]  b_cond;
    logic [2:0]  dest_reg;
    logic [2:0]  pointer_reg;
    logic [2:0]  op_1_reg;
    logic [2:0]  op_2_reg;
    logic [15:0] immediate;
    logic [15:0] offset;
    logic [3:0]  flags;

    logic [57:0] bundle;

    int checks = 0;
    int errors = 0;

    id_stage dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .if_valid    (if_valid),
        .if_instr    (if_instr),
        .if_ready    (if_ready),
        .ex_ready    (ex_ready),
        .ex_valid    (ex_valid),
        .flush       (flush),
        .flags_in    (flags_in),
        .flags_we    (flags_we),
        .first_ld    (first_ld),
        .special_enc (special_enc),
        .second_ld   (second_ld),
        .alu_oc      (alu_oc),
        .b_cond      (b_cond),
        .dest_reg    (dest_reg),
        .pointer_reg (pointer_reg),
        .op_1_reg    (op_1_reg),
        .op_2_reg    (op_2_reg),
        .immediate   (immediate),
        .offset      (offset),
        .flags       (flags)
    );

    always #5 clk = ~clk;

    assign bundle = {first_ld, special_enc, second_ld, alu_oc, b_cond, dest_reg,
                     pointer_reg, op_1_reg, op_2_reg, immediate, offset};

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n    = 1'b0;
        if_valid = 1'b0;
        if_instr = 32'h0;
        ex_ready = 1'b1;
        flush    = 1'b0;
        flags_in = 4'h0;
        flags_we = 1'b0;

        // ---------------- reset state ----------------
        #7;
        check("rst_ex_valid", ex_valid, 0);
        check("rst_if_ready", if_ready, 1);
        check("rst_flags",    flags,    0);
        check("rst_fields",   bundle,   0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();

        // ---------------- single word 4A5B_0007 ----------------
        if_valid = 1'b1;
        if_instr = 32'h4A5B_0007;
        tick();
        if_valid = 1'b0;
        check("w1_ex_valid",    ex_valid,    1);
        check("w1_first_ld",    first_ld,    2'b01);
        check("w1_special_enc", special_enc, 0);
        check("w1_second_ld",   second_ld,   4'h5);
        check("w1_b_cond",      b_cond,      4'h5);
        check("w1_alu_oc",      alu_oc,      3'b001);
        check("w1_dest_reg",    dest_reg,    3);
        check("w1_op_1_reg",    op_1_reg,    3);
        check("w1_pointer_reg", pointer_reg, 3);
        check("w1_op_2_reg",    op_2_reg,    7);
        check("w1_immediate",   immediate,   16'h0007);
        check("w1_offset",      offset,      16'h0000);
        tick();
        check("w1_drained", ex_valid, 0);

        // ---------------- NOP and branch offsets, back to back ----------------
        if_valid = 1'b1;
        if_instr = 32'h0000_0000;
        tick();
        check("nop_valid",  ex_valid, 1);
        check("nop_fields", bundle,   0);
        if_instr = 32'h8000_0FFE;
        tick();
        check("br_neg_first_ld", first_ld,  2'b10);
        check("br_neg_offset",   offset,    16'hFFFE);
        check("br_neg_imm",      immediate, 16'h0FFE);
        check("br_neg_op2",      op_2_reg,  6);
        if_instr = 32'h8000_07FF;
        tick();
        check("br_pos_offset", offset,   16'h07FF);
        check("br_pos_op2",    op_2_reg, 7);

        // ---------------- sustained stream, ex_ready high ----------------
        for (int i = 1; i <= 4; i++) begin
            if_instr = 32'h0000_0000 | i;
            tick();
            check("stream_valid", ex_valid,  1);
            check("stream_ready", if_ready,  1);
            check("stream_imm",   immediate, i);
        end
        if_valid = 1'b0;
        tick();
        check("stream_drained", ex_valid, 0);

        // ---------------- stall: A, B, C with ex_ready low ----------------
        ex_ready = 1'b0;
        if_valid = 1'b1;
        if_instr = 32'h0000_AAAA;
        tick();
        check("stall_a_valid", ex_valid,  1);
        check("stall_a_imm",   immediate, 16'hAAAA);
        if_instr = 32'h0000_BBBB;
        tick();
        check("stall_full_ready", if_ready,  0);
        check("stall_full_head",  immediate, 16'hAAAA);
        if_instr = 32'h0000_CCCC;
        tick();
        check("stall_hold_ready", if_ready,  0);
        check("stall_hold_head",  immediate, 16'hAAAA);
        tick();
        check("stall_hold2_head", immediate, 16'hAAAA);
        ex_ready = 1'b1;
        tick();
        check("rel_b_valid", ex_valid,  1);
        check("rel_b_imm",   immediate, 16'hBBBB);
        check("rel_b_ready", if_ready,  1);
        tick();
        if_valid = 1'b0;
        check("rel_c_imm", immediate, 16'hCCCC);
        tick();
        check("rel_drained", ex_valid, 0);

        // ---------------- flush in FULL with coincident input and flag write ----------------
        ex_ready = 1'b0;
        if_valid = 1'b1;
        if_instr = 32'h0000_1111;
        tick();
        if_instr = 32'h0000_2222;
        tick();
        check("fl_full_ready", if_ready, 0);
        flush    = 1'b1;
        if_instr = 32'h0000_3333;
        flags_we = 1'b1;
        flags_in = 4'b1010;
        tick();
        flush    = 1'b0;
        if_valid = 1'b0;
        flags_we = 1'b0;
        check("fl_ex_valid", ex_valid, 0);
        check("fl_if_ready", if_ready, 1);
        check("fl_fields",   bundle,   0);
        check("fl_flags",    flags,    4'b1010);
        ex_ready = 1'b1;
        tick();
        check("fl_no_ghost", ex_valid, 0);

        // ---------------- flush in ONE with coincident input ----------------
        ex_ready = 1'b0;
        if_valid = 1'b1;
        if_instr = 32'h0000_4444;
        tick();
        flush    = 1'b1;
        if_instr = 32'h0000_5555;
        tick();
        flush    = 1'b0;
        if_valid = 1'b0;
        check("fl1_ex_valid", ex_valid, 0);
        check("fl1_fields",   bundle,   0);
        ex_ready = 1'b1;
        tick();
        check("fl1_no_ghost", ex_valid, 0);

        // ---------------- flag write coincident with decode: no bypass ----------------
        if_valid = 1'b1;
        if_instr = 32'h0000_6666;
        flags_we = 1'b1;
        flags_in = 4'b0101;
        #1;
        check("fw_before_edge", flags, 4'b1010);
        tick();
        if_valid = 1'b0;
        flags_we = 1'b0;
        check("fw_after_edge", flags,     4'b0101);
        check("fw_head_imm",   immediate, 16'h6666);
        tick();

        // ---------------- asynchronous reset mid-stream ----------------
        ex_ready = 1'b0;
        if_valid = 1'b1;
        if_instr = 32'h0000_7777;
        tick();
        if_instr = 32'h0000_8888;
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_ex_valid", ex_valid, 0);
        check("arst_if_ready", if_ready, 1);
        check("arst_flags",    flags,    0);
        check("arst_fields",   bundle,   0);
        if_valid = 1'b0;
        #2;
        rst_n = 1'b1;
        tick();
        check("arst_idle", ex_valid, 0);
        ex_ready = 1'b1;
        if_valid = 1'b1;
        if_instr = 32'h4A5B_0007;
        tick();
        if_valid = 1'b0;
        check("arst_w_valid", ex_valid,  1);
        check("arst_w_imm",   immediate, 16'h0007);
        check("arst_w_dest",  dest_reg,  3);
        tick();
        check("arst_w_drained", ex_valid, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
